riscv_32_multicycle_ctrl: RTL

Multi-cycle control sequencer for the RV32 CPU. It steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK, and handshakes with instruction memory during fetch. It consumes the 3-bit instruction type from `riscv_32_instr_decoder` (000 R, 001 I, 010 U) and drives the write enables and mux selects for the IR, PC, register file, ALU operand mux and writeback mux.

---
 rtl/riscv_32_multicycle_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/riscv_32_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the RV32 core.
// Define RISCV_CTRL_RETIRE_CNT_EN to build the retired-instruction counter.
module riscv_32_multicycle_ctrl #(
    parameter int FETCH_TIMEOUT = 15,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic             imem_ack,
    input  logic [2:0]       instr_type,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             alu_src_imm,
    output logic             wb_sel_upper,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retire_cnt
);
    localparam int TW = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(FETCH_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d, tcnt_inc;
    logic [1:0]    cause_q, cause_d;
    logic [2:0]    type_q;
    logic          sel_phase;

    assign tcnt_inc = tcnt_q + TW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            cause_q <= 2'b00;
            type_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            cause_q <= cause_d;
            if (state_q == S_DECODE)
                type_q <= instr_type;
        end
    end

    // Timeout counter defaults to zero so it is clear on every FETCH entry.
    always_comb begin
        state_d = state_q;
        tcnt_d  = '0;
        cause_d = cause_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_DECODE;
                end else if (tcnt_inc == TO_LIMIT) begin
                    state_d = S_FAULT;
                    cause_d = 2'b01;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            S_DECODE: begin
                if (instr_type > 3'd2) begin
                    state_d = S_FAULT;
                    cause_d = 2'b10;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = halt_req ? S_IDLE : S_FETCH;
            S_FAULT: begin
                if (start) begin
                    state_d = S_IDLE;
                    cause_d = 2'b00;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    assign sel_phase    = (state_q == S_EXEC) || (state_q == S_WB);
    assign imem_req     = (state_q == S_FETCH);
    assign ir_we        = imem_req & imem_ack;
    assign pc_we        = (state_q == S_WB);
    assign rf_we        = (state_q == S_WB);
    assign alu_src_imm  = sel_phase && (type_q == 3'b001);
    assign wb_sel_upper = sel_phase && (type_q == 3'b010);
    assign fault        = (state_q == S_FAULT);
    assign fault_cause  = cause_q;
    assign state        = state_q;

`ifdef RISCV_CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] rcnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rcnt_q <= '0;
        else if (state_q == S_WB)
            rcnt_q <= rcnt_q + CNT_W'(1);
    end
    assign retire_cnt = rcnt_q;
`else
    assign retire_cnt = '0;
`endif

endmodule
